vec_mem_seq: RTL and testbench
==============================

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 The block SHALL have parameter LANES, default 16: number of 32-bit lanes per vector.
REQ-002 The block SHALL have parameter AW, default 13: data-memory word-address width.
REQ-003 The block SHALL have parameter DW, default 32: lane and memory word width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: CPU memory request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: request accepted this cycle.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_vec, input, 1 bit: 1 = vector (LANES beats), 0 = scalar (1 beat).
REQ-010 The block SHALL have port req_addr, input, AW bits: base word address.
REQ-011 The block SHALL have port req_wdata, input, LANES x DW bits: store data, lane-packed.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port rsp_rdata, output, LANES x DW bits: load result.
REQ-014 The block SHALL have port busy, output, 1 bit: pipeline stall request.
REQ-015 The block SHALL have port mem_en, output, 1 bit: memory access strobe.
REQ-016 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-017 The block SHALL have port mem_addr, output, AW bits: memory word address.
REQ-018 The block SHALL have port mem_wdata, output, DW bits: memory write data.
REQ-019 The block SHALL have port mem_rdata, input, DW bits: read data, valid one cycle after a read strobe.

Function
REQ-020 The FSM SHALL have the states IDLE, XFER, DRAIN and RESP.
REQ-021 req_ready SHALL equal 1 only in IDLE; an accepting cycle is req_valid & req_ready.
REQ-022 On accept, the block SHALL latch write, vec, addr and wdata, clear the beat counter, and go to XFER.
REQ-023 Vector beat k (k = 0..LANES-1) SHALL drive mem_en=1, mem_addr=(base+k) mod 2^AW and lane k.
REQ-024 The scalar single beat SHALL use mem_addr=base and lane LANES-1.
REQ-025 In XFER, mem_we SHALL equal the latched write bit, and mem_wdata SHALL be the lane data for stores and 0 for loads.
REQ-026 After the last beat, a load SHALL go XFER->DRAIN->RESP, and a store SHALL go XFER->RESP.
REQ-027 A load SHALL capture mem_rdata into the beat's lane on the cycle after that beat; captures SHALL be sequential.
REQ-028 At the start of a load, rsp_rdata SHALL be cleared, so non-addressed lanes of a scalar load read 0.
REQ-029 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; a new request can be accepted the next cycle.
REQ-030 rsp_rdata SHALL hold its value until the next load is accepted, and a store SHALL NOT change it.
REQ-031 Latency from the accept edge to rsp_valid SHALL be: vector load LANES+2, vector store LANES+1, scalar load 3, scalar store 2 cycles.
REQ-032 busy SHALL equal 1 in every state except IDLE.
REQ-033 mem_en SHALL be 0 outside XFER.
REQ-034 req_* inputs SHALL be ignored while busy.

Reset
REQ-035 rst SHALL force IDLE with req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 and beat counter=0.
REQ-036 rst asserted mid-transfer SHALL abort the transfer with no further memory strobes after deassertion and no response.

Configuration
REQ-037 With VMS_LANE_MASK_EN defined, the block SHALL add input req_mask (LANES bits), latched on accept.
REQ-038 With VMS_LANE_MASK_EN defined, a beat whose mask bit is 0 SHALL keep its cycle with mem_en=0, and its load lane SHALL stay 0.
REQ-039 With VMS_LANE_MASK_EN defined, scalar requests SHALL use mask bit LANES-1.
REQ-040 Without VMS_LANE_MASK_EN, the port SHALL be absent and all lanes SHALL be active; timing SHALL be identical in both builds.

Structure
REQ-041 Package vms_pkg SHALL hold the FSM state enum, the LANES/AW/DW defaults and the lane-vector typedef (LANES x DW packed).
REQ-042 Sub-module vms_lane_buf SHALL hold the lane capture/clear register for rsp_rdata; the FSM, beat counter and address generation SHALL live in vec_mem_seq.

Verification
REQ-043 Vector load: addr=0x010, memory[0x010+k]=0x100+k -> 16 read strobes on consecutive cycles, rsp_valid 18 cycles after accept, lane k=0x100+k.
REQ-044 Vector store: addr=0x1FFE, lane k=0xA0+k -> writes to 0x1FFE, 0x1FFF, 0x0000..0x000D; rsp_valid at +17; rsp_rdata unchanged.
REQ-045 Scalar load: addr=0x0042, memory=0xDEADBEEF -> one strobe, lane 15=0xDEADBEEF, lanes 0..14=0, rsp_valid at +3.
REQ-046 Back-to-back: req_valid held high with a scalar store then a scalar load -> second accept the cycle after rsp_valid; busy=1 between accepts; the load returns the stored value.
REQ-047 Reset abort: assert rst at beat 5 of a vector store -> mem_en=0 immediately, all outputs at reset values, no rsp_valid.
REQ-048 With VMS_LANE_MASK_EN, mask=0x00FF vector load -> mem_en high only for beats 0..7, lanes 8..15=0, rsp_valid still at +18.

Source files
------------

// File: rtl/vms_pkg.sv
// Shared definitions for the vector memory sequencer: FSM state encoding,
// default geometry and the lane-packed vector type.
package vms_pkg;

  localparam int LANES_DEF = 16;
  localparam int AW_DEF    = 13;
  localparam int DW_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } vmsState_e;

  typedef logic [LANES_DEF-1:0][DW_DEF-1:0] laneVec_t;

endpackage

// File: rtl/vms_if.sv
// CPU request/response and data-memory bus of the vector memory sequencer.
// Build option VMS_LANE_MASK_EN adds the per-lane request mask.
interface vms_if
  import vms_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic                       req_vec;
  logic [AW-1:0]              req_addr;
  logic [LANES-1:0][DW-1:0]   req_wdata;
`ifdef VMS_LANE_MASK_EN
  logic [LANES-1:0]           req_mask;
`endif
  logic                       rsp_valid;
  logic [LANES-1:0][DW-1:0]   rsp_rdata;
  logic                       busy;
  logic                       mem_en;
  logic                       mem_we;
  logic [AW-1:0]              mem_addr;
  logic [DW-1:0]              mem_wdata;
  logic [DW-1:0]              mem_rdata;

`ifdef VMS_LANE_MASK_EN
  modport master (
    output req_valid, req_write, req_vec, req_addr, req_wdata, req_mask, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_vec, req_addr, req_wdata, req_mask, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
`else
  modport master (
    output req_valid, req_write, req_vec, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_vec, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/vms_lane_buf.sv
// Load-result register: one DW-bit register per lane, cleared as a group
// when a load starts, then written one lane at a time.
module vms_lane_buf #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int LW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     capEn,
  input  logic [LW-1:0]            capLane,
  input  logic [DW-1:0]            capData,
  output logic [LANES*DW-1:0]      laneData
);

  for (genvar gi = 0; gi < LANES; gi++) begin : genLane
    logic [DW-1:0] laneReg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        laneReg <= '0;
      end else if (clr) begin
        laneReg <= '0;
      end else if (capEn && (capLane == LW'(gi))) begin
        laneReg <= capData;
      end
    end

    assign laneData[gi*DW +: DW] = laneReg;
  end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector/scalar load-store sequencer: serialises a LANES-wide request into
// single-word memory beats. Optional per-lane mask under VMS_LANE_MASK_EN.
module vec_mem_seq
  import vms_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic  clk,
  input  logic  rst,
  vms_if.slave  bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] XFER  = ST_XFER;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] RESP  = ST_RESP;

  logic [1:0]               stateReg, stateNext;
  logic [LW-1:0]            beatReg;
  logic                     writeReg, vecReg;
  logic [AW-1:0]            baseReg;
  logic [LANES-1:0][DW-1:0] wdataReg;
  logic                     capEnReg;
  logic [LW-1:0]            capLaneReg;

  logic                     accept, lastBeat, laneActive, inXfer;
  logic [LW-1:0]            lane;
  logic [AW-1:0]            offset;
  logic [LANES*DW-1:0]      laneData;

  assign accept   = (stateReg == IDLE) && bus.req_valid;
  assign inXfer   = (stateReg == XFER);
  // Scalar accesses always travel in the top lane.
  assign lane     = vecReg ? beatReg : LW'(LANES - 1);
  assign lastBeat = !vecReg || (beatReg == LW'(LANES - 1));
  assign offset   = vecReg ? AW'(beatReg) : '0;

`ifdef VMS_LANE_MASK_EN
  logic [LANES-1:0] maskReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maskReg <= '0;
    end else if (accept) begin
      maskReg <= bus.req_mask;
    end
  end

  assign laneActive = maskReg[lane];
`else
  assign laneActive = 1'b1;
`endif

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (accept) stateNext = XFER;
      XFER:    if (lastBeat) stateNext = writeReg ? RESP : DRAIN;
      DRAIN:   stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      beatReg    <= '0;
      writeReg   <= 1'b0;
      vecReg     <= 1'b0;
      baseReg    <= '0;
      wdataReg   <= '0;
      capEnReg   <= 1'b0;
      capLaneReg <= '0;
    end else begin
      stateReg   <= stateNext;
      // Read data arrives one cycle after its strobe; remember where it goes.
      capEnReg   <= inXfer && !writeReg && laneActive;
      capLaneReg <= lane;
      if (accept) begin
        writeReg <= bus.req_write;
        vecReg   <= bus.req_vec;
        baseReg  <= bus.req_addr;
        wdataReg <= bus.req_wdata;
        beatReg  <= '0;
      end else if (inXfer) begin
        beatReg  <= beatReg + LW'(1);
      end
    end
  end

  vms_lane_buf #(
    .LANES (LANES),
    .DW    (DW),
    .LW    (LW)
  ) uLaneBuf (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept && !bus.req_write),
    .capEn    (capEnReg),
    .capLane  (capLaneReg),
    .capData  (bus.mem_rdata),
    .laneData (laneData)
  );

  assign bus.req_ready = (stateReg == IDLE);
  assign bus.busy      = (stateReg != IDLE);
  assign bus.rsp_valid = (stateReg == RESP);
  assign bus.rsp_rdata = laneData;
  assign bus.mem_en    = inXfer && laneActive;
  assign bus.mem_we    = inXfer && writeReg;
  assign bus.mem_addr  = inXfer ? (baseReg + offset) : '0;
  assign bus.mem_wdata = (inXfer && writeReg) ? wdataReg[lane] : '0;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with a behavioural 8K-word memory.
// Define VMS_LANE_MASK_EN to also exercise the lane-mask build.
module tb_vec_mem_seq;
  import vms_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vms_if #(.LANES(16), .AW(13), .DW(32)) bus ();

  vec_mem_seq #(.LANES(16), .AW(13), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [0:8191];
  int          strobeAddr[$];
  logic        strobeWe[$];
  logic [31:0] strobeData[$];
  int          strobeCyc[$];
  int          cyc      = 0;
  int          rspCount = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rsp_valid) rspCount <= rspCount + 1;
    if (bus.mem_en) begin
      strobeAddr.push_back(int'(bus.mem_addr));
      strobeWe.push_back(bus.mem_we);
      strobeData.push_back(bus.mem_wdata);
      strobeCyc.push_back(cyc);
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic clearStrobes();
    strobeAddr.delete();
    strobeWe.delete();
    strobeData.delete();
    strobeCyc.delete();
  endtask

  // Issue one request, wait for its response; lat = cycle index (1 = first
  // cycle after the accept edge) in which rsp_valid is high.
  task automatic runReq(input string name, input logic w, input logic v,
                        input logic [12:0] a, input laneVec_t wd,
                        input logic [15:0] m, output int lat);
    int g;
    clearStrobes();
    bus.req_write = w;
    bus.req_vec   = v;
    bus.req_addr  = a;
    bus.req_wdata = wd;
`ifdef VMS_LANE_MASK_EN
    bus.req_mask  = m;
`endif
    bus.req_valid = 1'b1;
    g = 0;
    while (!bus.req_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checkVal({name, "_rspSeen"}, bus.rsp_valid, 1'b1);
    @(posedge clk); #1;
    checkVal({name, "_rspPulse"}, bus.rsp_valid, 1'b0);
    $display("TXN %s write=%0d vec=%0d addr=%h lat=%0d strobes=%0d", name, w, v, a, lat, strobeAddr.size());
  endtask

  laneVec_t wd, expVec, vldVec;
  int       lat;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    for (int k = 0; k < 16; k++) mem[13'h010 + k] = 32'h100 + k;
    mem[13'h042] = 32'hDEADBEEF;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_vec   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef VMS_LANE_MASK_EN
    bus.req_mask  = '1;
`endif
    bus.mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_ready", bus.req_ready, 1'b1);
    checkVal("rst_busy", bus.busy, 1'b0);
    checkVal("rst_rspValid", bus.rsp_valid, 1'b0);
    checkVal("rst_rdata", bus.rsp_rdata, '0);
    checkVal("rst_memEn", bus.mem_en, 1'b0);
    checkVal("rst_memWe", bus.mem_we, 1'b0);
    checkVal("rst_memAddr", bus.mem_addr, '0);
    checkVal("rst_memWdata", bus.mem_wdata, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector load from 0x010
    runReq("vld", 1'b0, 1'b1, 13'h010, '0, 16'hFFFF, lat);
    checkVal("vld_lat", lat, 18);
    checkVal("vld_nStrobe", strobeAddr.size(), 16);
    if (strobeAddr.size() > 0)
      checkVal("vld_consec", strobeCyc[strobeCyc.size()-1] - strobeCyc[0], strobeCyc.size() - 1);
    for (int k = 0; k < strobeAddr.size(); k++) begin
      checkVal($sformatf("vld_addr%0d", k), strobeAddr[k], 32'h010 + k);
      checkVal($sformatf("vld_we%0d", k), strobeWe[k], 1'b0);
      checkVal($sformatf("vld_wdata%0d", k), strobeData[k], 32'h0);
    end
    for (int k = 0; k < 16; k++) vldVec[k] = 32'h100 + k;
    checkVal("vld_rdata", bus.rsp_rdata, vldVec);
    checkVal("vld_idleReady", bus.req_ready, 1'b1);

    // Vector store wrapping past the top of memory
    for (int k = 0; k < 16; k++) wd[k] = 32'hA0 + k;
    runReq("vst", 1'b1, 1'b1, 13'h1FFE, wd, 16'hFFFF, lat);
    checkVal("vst_lat", lat, 17);
    checkVal("vst_nStrobe", strobeAddr.size(), 16);
    for (int k = 0; k < strobeAddr.size(); k++) begin
      checkVal($sformatf("vst_addr%0d", k), strobeAddr[k], (32'h1FFE + k) & 32'h1FFF);
      checkVal($sformatf("vst_we%0d", k), strobeWe[k], 1'b1);
      checkVal($sformatf("vst_wdata%0d", k), strobeData[k], 32'hA0 + k);
    end
    checkVal("vst_mem1FFF", mem[13'h1FFF], 32'hA1);
    checkVal("vst_mem000D", mem[13'h000D], 32'hAF);
    checkVal("vst_mem000E", mem[13'h000E], 32'h0);
    checkVal("vst_rdataKept", bus.rsp_rdata, vldVec);

    // Scalar load: lane 15 only, other lanes cleared
    for (int k = 0; k < 16; k++) wd[k] = 32'h5555_0000 + k;
    runReq("sld", 1'b0, 1'b0, 13'h0042, wd, 16'h8000, lat);
    checkVal("sld_lat", lat, 3);
    checkVal("sld_nStrobe", strobeAddr.size(), 1);
    if (strobeAddr.size() > 0) checkVal("sld_addr", strobeAddr[0], 32'h42);
    expVec = '0;
    expVec[15] = 32'hDEADBEEF;
    checkVal("sld_rdata", bus.rsp_rdata, expVec);

    // Back-to-back scalar store then scalar load with req_valid held high
    clearStrobes();
    for (int k = 0; k < 15; k++) wd[k] = 32'hBAD0 + k;
    wd[15] = 32'h12345678;
    bus.req_write = 1'b1;
    bus.req_vec   = 1'b0;
    bus.req_addr  = 13'h0055;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    checkVal("b2b_busy1", bus.busy, 1'b1);
    checkVal("b2b_memWdata", bus.mem_wdata, 32'h12345678);
    @(posedge clk); #1;
    checkVal("b2b_busy2", bus.busy, 1'b1);
    checkVal("b2b_rsp1", bus.rsp_valid, 1'b1);
    @(posedge clk); #1;
    checkVal("b2b_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkVal("b2b_accept2", bus.busy, 1'b1);
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checkVal("b2b_ldLat", lat, 3);
    expVec = '0;
    expVec[15] = 32'h12345678;
    checkVal("b2b_rdata", bus.rsp_rdata, expVec);
    checkVal("b2b_nStrobe", strobeAddr.size(), 2);
    checkVal("b2b_mem", mem[13'h0055], 32'h12345678);
    $display("TXN b2b store+load addr=0055 ldLat=%0d strobes=%0d", lat, strobeAddr.size());
    @(posedge clk); #1;

`ifdef VMS_LANE_MASK_EN
    // Masked vector load: only beats 0..7 strobe
    runReq("mld", 1'b0, 1'b1, 13'h010, '0, 16'h00FF, lat);
    checkVal("mld_lat", lat, 18);
    checkVal("mld_nStrobe", strobeAddr.size(), 8);
    for (int k = 0; k < strobeAddr.size(); k++)
      checkVal($sformatf("mld_addr%0d", k), strobeAddr[k], 32'h010 + k);
    expVec = '0;
    for (int k = 0; k < 8; k++) expVec[k] = 32'h100 + k;
    checkVal("mld_rdata", bus.rsp_rdata, expVec);
`endif

    // Reset abort at beat 5 of a vector store
    clearStrobes();
    for (int k = 0; k < 16; k++) wd[k] = 32'hC0 + k;
    bus.req_write = 1'b1;
    bus.req_vec   = 1'b1;
    bus.req_addr  = 13'h0200;
    bus.req_wdata = wd;
`ifdef VMS_LANE_MASK_EN
    bus.req_mask  = '1;
`endif
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkVal("abt_beat5Addr", bus.mem_addr, 13'h0205);
    checkVal("abt_preStrobes", strobeAddr.size(), 5);
    rst = 1'b1;
    #1;
    checkVal("abt_memEn", bus.mem_en, 1'b0);
    checkVal("abt_memWe", bus.mem_we, 1'b0);
    checkVal("abt_memAddr", bus.mem_addr, '0);
    checkVal("abt_memWdata", bus.mem_wdata, '0);
    checkVal("abt_ready", bus.req_ready, 1'b1);
    checkVal("abt_busy", bus.busy, 1'b0);
    checkVal("abt_rsp", bus.rsp_valid, 1'b0);
    checkVal("abt_rdata", bus.rsp_rdata, '0);
    rspCount = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    clearStrobes();
    repeat (30) @(posedge clk);
    #1;
    checkVal("abt_postStrobes", strobeAddr.size(), 0);
    checkVal("abt_noRsp", rspCount, 0);
    checkVal("abt_mem205", mem[13'h0205], 32'h0);
    checkVal("abt_mem204", mem[13'h0204], 32'hC4);
    $display("TXN abort vst addr=0200 rspAfter=%0d", rspCount);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
